// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the IF stage and IF/ID pipeline register.
package if_id_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    // Source of the next PC value.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // A redirect beats a stall; otherwise PCWrite decides advance vs hold.
    function automatic pc_sel_e pc_select(input logic branch_taken, input logic pc_write);
        if (branch_taken) return PC_REDIRECT;
        if (pc_write)     return PC_SEQ;
        return PC_HOLD;
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Control, instruction-memory and IF/ID output bundle for if_id_stage.
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic               PCWrite;
    logic               IFIDWrite;
    logic               BranchTaken;
    logic [31:0]        BranchTarget;
    logic [31:0]        IMemAddr;
    logic [INSTR_W-1:0] IMemData;
    logic [INSTR_W-1:0] IFIDInstr;
    logic [31:0]        IFIDPCPlus4;
    logic               IFIDValid;
    logic [4:0]         IFIDrs;
    logic [4:0]         IFIDrt;
    logic [31:0]        StallCount;
    logic [31:0]        FlushCount;

    // Driver side: hazard/branch units and instruction memory.
    modport master (
        output PCWrite, IFIDWrite, BranchTaken, BranchTarget, IMemData,
        input  IMemAddr, IFIDInstr, IFIDPCPlus4, IFIDValid, IFIDrs, IFIDrt,
               StallCount, FlushCount
    );

    // Fetch stage side.
    modport slave (
        input  PCWrite, IFIDWrite, BranchTaken, BranchTarget, IMemData,
        output IMemAddr, IFIDInstr, IFIDPCPlus4, IFIDValid, IFIDrs, IFIDrt,
               StallCount, FlushCount
    );

endinterface

// File: rtl/if_id_stage_pc_register.sv
// Program counter with redirect/advance/hold selection and wrapping incrementer.
module pc_register
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    pc_sel_e     sel;
    logic [31:0] pc_next;

    assign pc_plus4 = pc + 32'(PC_INC);

    // Next-PC mux.
    always_comb begin
        sel     = pc_select(branch_taken, pc_write);
        pc_next = pc;
        unique case (sel)
            PC_REDIRECT: pc_next = branch_target;
            PC_SEQ:      pc_next = pc_plus4;
            default:     pc_next = pc;
        endcase
    end

    // PC flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Optional: define STALL_COUNT_EN to enable saturating stall/flush counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic Clk,
    input  logic Reset,
    if_id_stage_if.slave bus
);

    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic [INSTR_W-1:0] ifid_instr;
    logic [31:0]        ifid_pc_plus4;
    logic               ifid_valid;

    pc_register #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_register (
        .clk           (Clk),
        .rst           (Reset),
        .pc_write      (bus.PCWrite),
        .branch_taken  (bus.BranchTaken),
        .branch_target (bus.BranchTarget),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    assign bus.IMemAddr    = pc;
    assign bus.IFIDInstr   = ifid_instr;
    assign bus.IFIDPCPlus4 = ifid_pc_plus4;
    assign bus.IFIDValid   = ifid_valid;
    assign bus.IFIDrs      = ifid_instr[RS_MSB:RS_LSB];
    assign bus.IFIDrt      = ifid_instr[RT_MSB:RT_LSB];

    // IF/ID register: flush on redirect, load when enabled, else hold.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else if (bus.BranchTaken) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else if (bus.IFIDWrite) begin
            ifid_instr    <= bus.IMemData;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    // Saturating counters: stalls are PC-hold edges not overridden by a redirect.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!bus.PCWrite && !bus.BranchTaken && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
            if (bus.BranchTaken && (flush_count != '1))
                flush_count <= flush_count + 32'd1;
        end
    end

    assign bus.StallCount = stall_count;
    assign bus.FlushCount = flush_count;
`else
    assign bus.StallCount = '0;
    assign bus.FlushCount = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage against a cycle-level behavioural model.
module tb_if_id_stage;

    logic clk;
    logic rst;

    if_id_stage_if bus();

    if_id_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pcp4, m_stall, m_flush;
    logic        m_valid;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.IMemData = mem_word(bus.IMemAddr);

    function automatic logic [31:0] exp_stall();
`ifdef STALL_COUNT_EN
        return m_stall;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush();
`ifdef STALL_COUNT_EN
        return m_flush;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        m_stall = 32'h0; m_flush = 32'h0;
    endtask

    // Apply controls for one edge and advance the model by that edge.
    task automatic step(input logic pw, input logic iw, input logic bt, input logic [31:0] tgt);
        logic [31:0] fetched;
        bus.PCWrite = pw; bus.IFIDWrite = iw; bus.BranchTaken = bt; bus.BranchTarget = tgt;
        @(posedge clk);
        fetched = mem_word(m_pc);
        if (bt) begin
            m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        end else if (iw) begin
            m_instr = fetched; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        if (!pw && !bt && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (bt && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
        if (bt)      m_pc = tgt;
        else if (pw) m_pc = m_pc + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PCWrite = 1'b0; bus.IFIDWrite = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = 32'h0;
        model_reset();
        #12;
        n_cmp++; if (bus.IMemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.IMemAddr, 32'h0); end
        n_cmp++; if (bus.IFIDValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.IFIDValid); end
        n_cmp++; if (bus.IFIDInstr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.IFIDInstr); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (bus.IFIDInstr !== 32'h8C22_0004) begin n_fail++; $display("FAIL first_instr: got %h want 8c220004", bus.IFIDInstr); end
        n_cmp++; if (bus.IFIDrs !== 5'd1) begin n_fail++; $display("FAIL first_rs: got %0d want 1", bus.IFIDrs); end
        n_cmp++; if (bus.IFIDrt !== 5'd2) begin n_fail++; $display("FAIL first_rt: got %0d want 2", bus.IFIDrt); end
        n_cmp++; if (bus.IFIDPCPlus4 !== 32'd4) begin n_fail++; $display("FAIL first_pcp4: got %h want 4", bus.IFIDPCPlus4); end
        n_cmp++; if (bus.IFIDValid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", bus.IFIDValid); end
        n_cmp++; if (bus.IMemAddr !== 32'd4) begin n_fail++; $display("FAIL first_addr: got %h want 4", bus.IMemAddr); end
    endtask

    task automatic test_load_use_stall();
        logic [31:0] held;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        held = bus.IFIDInstr;
        n_cmp++; if (held !== mem_word(32'd4)) begin n_fail++; $display("FAIL pre_stall_instr: got %h want %h", held, mem_word(32'd4)); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++; if (bus.IMemAddr !== 32'd8) begin n_fail++; $display("FAIL stall_addr: got %h want 8", bus.IMemAddr); end
            n_cmp++; if (bus.IFIDInstr !== mem_word(32'd4)) begin n_fail++; $display("FAIL stall_hold: got %h want %h", bus.IFIDInstr, mem_word(32'd4)); end
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (bus.IMemAddr !== 32'd12) begin n_fail++; $display("FAIL stall_release_addr: got %h want c", bus.IMemAddr); end
        n_cmp++; if (bus.IFIDInstr !== mem_word(32'd8)) begin n_fail++; $display("FAIL stall_release_instr: got %h want %h", bus.IFIDInstr, mem_word(32'd8)); end
`ifdef STALL_COUNT_EN
        n_cmp++; if (bus.StallCount !== 32'd2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", bus.StallCount); end
`else
        n_cmp++; if (bus.StallCount !== 32'd0) begin n_fail++; $display("FAIL stall_count_off: got %0d want 0", bus.StallCount); end
`endif
    endtask

    task automatic test_branch();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (bus.IMemAddr !== 32'd16) begin n_fail++; $display("FAIL pre_branch_addr: got %h want 10", bus.IMemAddr); end
        step(1'b1, 1'b1, 1'b1, 32'h40);
        n_cmp++; if (bus.IMemAddr !== 32'h40) begin n_fail++; $display("FAIL branch_addr: got %h want 40", bus.IMemAddr); end
        n_cmp++; if (bus.IFIDInstr !== 32'h0) begin n_fail++; $display("FAIL branch_flush_instr: got %h want 0", bus.IFIDInstr); end
        n_cmp++; if (bus.IFIDValid !== 1'b0) begin n_fail++; $display("FAIL branch_flush_valid: got %b want 0", bus.IFIDValid); end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (bus.IFIDInstr !== mem_word(32'h40)) begin n_fail++; $display("FAIL branch_target_instr: got %h want %h", bus.IFIDInstr, mem_word(32'h40)); end
        n_cmp++; if (bus.IFIDPCPlus4 !== 32'h44) begin n_fail++; $display("FAIL branch_target_pcp4: got %h want 44", bus.IFIDPCPlus4); end
    endtask

    task automatic test_branch_during_stall();
        logic [31:0] stall_before, flush_before;
        stall_before = exp_stall();
        flush_before = exp_flush();
        step(1'b0, 1'b0, 1'b1, 32'h80);
        n_cmp++; if (bus.IMemAddr !== 32'h80) begin n_fail++; $display("FAIL stall_branch_addr: got %h want 80", bus.IMemAddr); end
        n_cmp++; if (bus.IFIDValid !== 1'b0) begin n_fail++; $display("FAIL stall_branch_valid: got %b want 0", bus.IFIDValid); end
        n_cmp++; if (bus.StallCount !== stall_before) begin n_fail++; $display("FAIL stall_branch_stallcnt: got %0d want %0d", bus.StallCount, stall_before); end
`ifdef STALL_COUNT_EN
        n_cmp++; if (bus.FlushCount !== flush_before + 32'd1) begin n_fail++; $display("FAIL stall_branch_flushcnt: got %0d want %0d", bus.FlushCount, flush_before + 32'd1); end
`else
        n_cmp++; if (bus.FlushCount !== flush_before) begin n_fail++; $display("FAIL stall_branch_flushcnt: got %0d want %0d", bus.FlushCount, flush_before); end
`endif
    endtask

    task automatic test_wrap_async_reset();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        n_cmp++; if (bus.IMemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want fffffffc", bus.IMemAddr); end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        n_cmp++; if (bus.IMemAddr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", bus.IMemAddr); end
        n_cmp++; if (bus.IFIDPCPlus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcp4: got %h want 0", bus.IFIDPCPlus4); end
        n_cmp++; if (bus.IFIDInstr !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", bus.IFIDInstr, mem_word(32'hFFFF_FFFC)); end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus.IMemAddr !== 32'h0) begin n_fail++; $display("FAIL async_pc: got %h want 0", bus.IMemAddr); end
        n_cmp++; if (bus.IFIDInstr !== 32'h0) begin n_fail++; $display("FAIL async_instr: got %h want 0", bus.IFIDInstr); end
        n_cmp++; if (bus.IFIDPCPlus4 !== 32'h0) begin n_fail++; $display("FAIL async_pcp4: got %h want 0", bus.IFIDPCPlus4); end
        n_cmp++; if (bus.IFIDValid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", bus.IFIDValid); end
        n_cmp++; if (bus.StallCount !== 32'h0) begin n_fail++; $display("FAIL async_stallcnt: got %0d want 0", bus.StallCount); end
        n_cmp++; if (bus.FlushCount !== 32'h0) begin n_fail++; $display("FAIL async_flushcnt: got %0d want 0", bus.FlushCount); end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic pw, iw, bt;
        logic [31:0] tgt;
        for (int i = 0; i < 300; i++) begin
            pw  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 3) != 0);
            bt  = ($urandom_range(0, 6) == 0);
            tgt = {$urandom(), 2'b00} & 32'h0000_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = $urandom() & 32'hFFFF_FFFC;
            step(pw, iw, bt, tgt);
            n_cmp++; if (bus.IMemAddr !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, bus.IMemAddr, m_pc); end
            n_cmp++; if (bus.IFIDInstr !== m_instr) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", i, bus.IFIDInstr, m_instr); end
            n_cmp++; if (bus.IFIDPCPlus4 !== m_pcp4) begin n_fail++; $display("FAIL rand_pcp4[%0d]: got %h want %h", i, bus.IFIDPCPlus4, m_pcp4); end
            n_cmp++; if (bus.IFIDValid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.IFIDValid, m_valid); end
            n_cmp++; if (bus.IFIDrs !== m_instr[25:21]) begin n_fail++; $display("FAIL rand_rs[%0d]: got %0d want %0d", i, bus.IFIDrs, m_instr[25:21]); end
            n_cmp++; if (bus.IFIDrt !== m_instr[20:16]) begin n_fail++; $display("FAIL rand_rt[%0d]: got %0d want %0d", i, bus.IFIDrt, m_instr[20:16]); end
            n_cmp++; if (bus.StallCount !== exp_stall()) begin n_fail++; $display("FAIL rand_stallcnt[%0d]: got %0d want %0d", i, bus.StallCount, exp_stall()); end
            n_cmp++; if (bus.FlushCount !== exp_flush()) begin n_fail++; $display("FAIL rand_flushcnt[%0d]: got %0d want %0d", i, bus.FlushCount, exp_flush()); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use_stall();
        test_branch();
        test_branch_during_stall();
        test_wrap_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
